// File: rtl/pi_out_sched_pkg.sv
// Shared constants and helpers for the pi switch output scheduler.
//   DEFAULT_VC_W    : default number of virtual channels
//   DEFAULT_CREDITS : default downstream buffer depth per VC
//   vc_of()         : VC of a flat requester index (idx = dir*VC_W + vc)
package pi_out_sched_pkg;

   localparam int unsigned DEFAULT_VC_W    = 2;
   localparam int unsigned DEFAULT_CREDITS = 4;

   // VC is preserved through the switch, so a requester's VC is its low index digit
   function automatic int unsigned vc_of(input int unsigned idx, input int unsigned vc_w);
      return idx % vc_w;
   endfunction

endpackage

// File: rtl/pi_rr_arb.sv
// Combinational masked-priority round-robin arbiter.
//   req        : request vector
//   ptr        : highest-priority index this cycle
//   gnt_onehot : one-hot grant (zero when no request)
//   gnt_idx    : binary index of the grant (zero when no request)
//   any        : at least one request present
module pi_rr_arb #(
   parameter int unsigned N = 6
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt_onehot,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 any
);

   localparam int unsigned IW = $clog2(N);

   logic [N-1:0] req_hi;
   logic [N-1:0] pick_src;

   // Prefer requests at or above ptr; otherwise wrap to the lowest request
   always_comb begin
      req_hi     = req & ~((N'(1) << ptr) - N'(1));
      pick_src   = (req_hi != '0) ? req_hi : req;
      gnt_onehot = pick_src & (~pick_src + N'(1));
      any        = |req;
      gnt_idx    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt_onehot == (N'(1) << i)) gnt_idx = IW'(i);
      end
   end

endmodule

// File: rtl/pi_out_sched.sv
// Per-output-port scheduler: round-robin among (dir, VC) requesters, gated by
// per-VC downstream credits. Grant is combinational (same-cycle payload).
//   clk, rst  : clock, asynchronous active-low reset
//   req_v     : request valid per flat requester (idx = dir*VC_W + vc)
//   req_bp    : backpressure, low only on the requester granted this cycle
//   cred_ret  : one credit returned per VC per cycle
//   sel       : output mux select (flat index of the grant, 0 when idle)
//   o_v       : output valid, one-hot on the granted VC
//   cred      : current credit counters, VC v at [v*CRED_W +: CRED_W]
//   err       : sticky credit-overflow flag
module pi_out_sched
   import pi_out_sched_pkg::*;
#(
   parameter int unsigned NUM_DIR = 3,
   parameter int unsigned VC_W    = DEFAULT_VC_W,
   parameter int unsigned CREDITS = DEFAULT_CREDITS
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_DIR*VC_W-1:0]               req_v,
   output logic [NUM_DIR*VC_W-1:0]               req_bp,
   input  logic [VC_W-1:0]                       cred_ret,
   output logic [$clog2(NUM_DIR*VC_W)-1:0]       sel,
   output logic [VC_W-1:0]                       o_v,
   output logic [VC_W*$clog2(CREDITS+1)-1:0]     cred,
   output logic                                  err
);

   localparam int unsigned N_REQ  = NUM_DIR * VC_W;
   localparam int unsigned SEL_W  = $clog2(N_REQ);
   localparam int unsigned CRED_W = $clog2(CREDITS + 1);

   // Requesters belonging to VC v
   function automatic logic [N_REQ-1:0] vc_mask(input int unsigned v);
      logic [N_REQ-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (vc_of(i, VC_W) == v) m = m | (N_REQ'(1) << i);
      end
      return m;
   endfunction

   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] gnt_idx;
   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] gnt_onehot;
   logic             gnt_any;
   logic [VC_W-1:0]  ovf;
   logic             err_q;

   // Eligibility; holding reset low forces every output idle
   for (genvar i = 0; i < N_REQ; i++) begin : g_req
      localparam int unsigned VC = vc_of(i, VC_W);
      assign eligible[i] = rst & req_v[i] & (cred[VC*CRED_W +: CRED_W] != '0);
   end

   pi_rr_arb #(.N(N_REQ)) u_arb (
      .req        (eligible),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   assign sel    = gnt_idx;
   assign req_bp = ~gnt_onehot;

   // Per-VC output valid and credit counter
   for (genvar v = 0; v < VC_W; v++) begin : g_vc
      localparam logic [N_REQ-1:0] MASK = vc_mask(v);
      logic [CRED_W-1:0] cnt_q;

      assign o_v[v] = |(gnt_onehot & MASK);
      assign ovf[v] = cred_ret[v] & ~o_v[v] & (cnt_q == CRED_W'(CREDITS));
      assign cred[v*CRED_W +: CRED_W] = cnt_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= CRED_W'(CREDITS);
         end else begin
            case ({o_v[v], cred_ret[v]})
               2'b10:   cnt_q <= cnt_q - CRED_W'(1);
               2'b01:   if (cnt_q != CRED_W'(CREDITS)) cnt_q <= cnt_q + CRED_W'(1);
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end

   // Round-robin pointer: next priority goes to the index after the grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else if (gnt_any) begin
         ptr_q <= (gnt_idx == SEL_W'(N_REQ - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
   end

   // Sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      err_q <= 1'b0;
      else if (|ovf) err_q <= 1'b1;
   end

   assign err = err_q;

endmodule
